// File: rtl/uriscv_bus_pkg.sv
// uriscv_bus_pkg: shared types and constants for the uriscv Wishbone bus bridges.
//   state_t   - arbiter bus state (IDLE / BUS_I / BUS_D)
//   owner_t   - which core port owns (or last owned) the bus
//   wb_req_t  - registered Wishbone request payload (we/sel/adr/dat)
package uriscv_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS_I = 2'd1,
      BUS_D = 2'd2
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   localparam logic [3:0]  SEL_WORD        = 4'hF;
   localparam int unsigned TIMEOUT_DEFAULT = 255;

   typedef struct packed {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } wb_req_t;

   // Wishbone addresses are word aligned; byte lanes go through sel.
   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: bus watchdog shared by the uriscv bus bridges.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   clear        - hold the count at zero (bus idle)
//   run          - count one cycle per clock (transaction outstanding)
//   expired      - high in the TIMEOUT-th cycle of run; never with TIMEOUT=0
// expired is decoded from the count so the owner can abort on that same edge.
module wb_timeout_counter
   import uriscv_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : 32'($clog2(TIMEOUT));
   localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Count cycles of run; freeze once expired so the compare stays stable.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (TIMEOUT != 0) && run && !clear && (count == LAST);

endmodule

// File: rtl/uriscv_wb_arbiter.sv
// uriscv_wb_arbiter: shares one Wishbone classic master between the riscv_core
// instruction-fetch port and data port, one transaction at a time.
//   clk_i, rst_i        - clock, asynchronous active-high reset
//   mem_i_*             - fetch port (rd/pc in; accept/valid/inst/error out)
//   mem_d_*             - data port (addr/data/rd/wr/tag/maintenance in;
//                         accept/ack/data/error/tag out)
//   wb_*                - Wishbone classic master
// Accepts are combinational; every other output is a flop.
module uriscv_wb_arbiter
   import uriscv_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned TAG_W   = 11
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mem_i_rd_i,
   input  logic [31:0]      mem_i_pc_i,
   input  logic             mem_i_flush_i,
   input  logic             mem_i_invalidate_i,
   output logic             mem_i_accept_o,
   output logic             mem_i_valid_o,
   output logic [31:0]      mem_i_inst_o,
   output logic             mem_i_error_o,
   input  logic [31:0]      mem_d_addr_i,
   input  logic [31:0]      mem_d_data_wr_i,
   input  logic             mem_d_rd_i,
   input  logic [3:0]       mem_d_wr_i,
   input  logic [TAG_W-1:0] mem_d_req_tag_i,
   input  logic             mem_d_invalidate_i,
   input  logic             mem_d_writeback_i,
   input  logic             mem_d_flush_i,
   output logic             mem_d_accept_o,
   output logic             mem_d_ack_o,
   output logic [31:0]      mem_d_data_rd_o,
   output logic             mem_d_error_o,
   output logic [TAG_W-1:0] mem_d_resp_tag_o,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   output logic             wb_we_o,
   output logic [3:0]       wb_sel_o,
   output logic [31:0]      wb_adr_o,
   output logic [31:0]      wb_dat_o,
   input  logic [31:0]      wb_dat_i,
   input  logic             wb_ack_i
);

   state_t           state;
   owner_t           last_grant;
   wb_req_t          wb_q;
   logic             wb_act_q;
   logic             store_q;
   logic [TAG_W-1:0] tag_q;

   logic req_i_c, maint_d_c, access_d_c, req_d_c;
   logic grant_i_c, grant_d_c, idle_c, expired;
   logic unused_c;

   // I-cache maintenance has no bus side effect here and is dropped.
   assign unused_c = ^{mem_i_flush_i, mem_i_invalidate_i};

   // Round-robin: on contention the port that did not win last time goes.
   assign req_i_c    = mem_i_rd_i;
   assign maint_d_c  = mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
   assign access_d_c = mem_d_rd_i | (|mem_d_wr_i);
   assign req_d_c    = access_d_c | maint_d_c;
   assign grant_d_c  = req_d_c & (~req_i_c | (last_grant == OWN_I));
   assign grant_i_c  = req_i_c & ~grant_d_c;
   assign idle_c     = (state == IDLE);

   assign mem_i_accept_o = idle_c & grant_i_c;
   assign mem_d_accept_o = idle_c & grant_d_c;

   assign wb_cyc_o = wb_act_q;
   assign wb_stb_o = wb_act_q;
   assign wb_we_o  = wb_q.we;
   assign wb_sel_o = wb_q.sel;
   assign wb_adr_o = wb_q.adr;
   assign wb_dat_o = wb_q.dat;

   wb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear   (idle_c),
      .run     (~idle_c),
      .expired (expired)
   );

   // Bus FSM: launch in IDLE, finish on ack or watchdog expiry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state            <= IDLE;
         last_grant       <= OWN_I;
         wb_q             <= '0;
         wb_act_q         <= 1'b0;
         store_q          <= 1'b0;
         tag_q            <= '0;
         mem_i_valid_o    <= 1'b0;
         mem_i_inst_o     <= '0;
         mem_i_error_o    <= 1'b0;
         mem_d_ack_o      <= 1'b0;
         mem_d_data_rd_o  <= '0;
         mem_d_error_o    <= 1'b0;
         mem_d_resp_tag_o <= '0;
      end else begin
         mem_i_valid_o <= 1'b0;
         mem_i_error_o <= 1'b0;
         mem_d_ack_o   <= 1'b0;
         mem_d_error_o <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d_c) begin
                  last_grant <= OWN_D;
                  if (access_d_c) begin
                     // A store wins over a simultaneous load.
                     wb_act_q <= 1'b1;
                     wb_q.we  <= |mem_d_wr_i;
                     wb_q.sel <= (|mem_d_wr_i) ? mem_d_wr_i : SEL_WORD;
                     wb_q.adr <= word_addr(mem_d_addr_i);
                     wb_q.dat <= mem_d_data_wr_i;
                     store_q  <= |mem_d_wr_i;
                     tag_q    <= mem_d_req_tag_i;
                     state    <= BUS_D;
                  end else begin
                     // Maintenance completes locally without a bus cycle.
                     mem_d_ack_o      <= 1'b1;
                     mem_d_data_rd_o  <= '0;
                     mem_d_resp_tag_o <= mem_d_req_tag_i;
                  end
               end else if (grant_i_c) begin
                  last_grant <= OWN_I;
                  wb_act_q   <= 1'b1;
                  wb_q.we    <= 1'b0;
                  wb_q.sel   <= SEL_WORD;
                  wb_q.adr   <= word_addr(mem_i_pc_i);
                  state      <= BUS_I;
               end
            end
            BUS_I: begin
               if (wb_ack_i || expired) begin
                  wb_act_q      <= 1'b0;
                  mem_i_valid_o <= 1'b1;
                  mem_i_error_o <= ~wb_ack_i;
                  mem_i_inst_o  <= wb_ack_i ? wb_dat_i : 32'h0;
                  state         <= IDLE;
               end
            end
            BUS_D: begin
               if (wb_ack_i || expired) begin
                  wb_act_q         <= 1'b0;
                  mem_d_ack_o      <= 1'b1;
                  mem_d_error_o    <= ~wb_ack_i;
                  mem_d_data_rd_o  <= (wb_ack_i && !store_q) ? wb_dat_i : 32'h0;
                  mem_d_resp_tag_o <= tag_q;
                  state            <= IDLE;
               end
            end
            default: begin
               wb_act_q <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uriscv_wb_arbiter.sv
// tb_uriscv_wb_arbiter: scenario tasks driving uriscv_wb_arbiter; expected
// responses are queued at accept time and matched when a response pulses.
module tb_uriscv_wb_arbiter;

   localparam int unsigned TAG_W = 11;
   localparam int unsigned TMO   = 4;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             mem_i_rd_i;
   logic [31:0]      mem_i_pc_i;
   logic             mem_i_flush_i;
   logic             mem_i_invalidate_i;
   logic             mem_i_accept_o;
   logic             mem_i_valid_o;
   logic [31:0]      mem_i_inst_o;
   logic             mem_i_error_o;
   logic [31:0]      mem_d_addr_i;
   logic [31:0]      mem_d_data_wr_i;
   logic             mem_d_rd_i;
   logic [3:0]       mem_d_wr_i;
   logic [TAG_W-1:0] mem_d_req_tag_i;
   logic             mem_d_invalidate_i;
   logic             mem_d_writeback_i;
   logic             mem_d_flush_i;
   logic             mem_d_accept_o;
   logic             mem_d_ack_o;
   logic [31:0]      mem_d_data_rd_o;
   logic             mem_d_error_o;
   logic [TAG_W-1:0] mem_d_resp_tag_o;
   logic             wb_cyc_o;
   logic             wb_stb_o;
   logic             wb_we_o;
   logic [3:0]       wb_sel_o;
   logic [31:0]      wb_adr_o;
   logic [31:0]      wb_dat_o;
   logic [31:0]      wb_dat_i;
   logic             wb_ack_i;

   logic [151:0] all_out;
   assign all_out = {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
                     mem_i_accept_o, mem_i_valid_o, mem_i_inst_o, mem_i_error_o,
                     mem_d_accept_o, mem_d_ack_o, mem_d_data_rd_o, mem_d_error_o,
                     mem_d_resp_tag_o};

   typedef struct {
      logic             is_d;
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      logic             err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   uriscv_wb_arbiter #(
      .TIMEOUT (TMO),
      .TAG_W   (TAG_W)
   ) dut (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .mem_i_rd_i         (mem_i_rd_i),
      .mem_i_pc_i         (mem_i_pc_i),
      .mem_i_flush_i      (mem_i_flush_i),
      .mem_i_invalidate_i (mem_i_invalidate_i),
      .mem_i_accept_o     (mem_i_accept_o),
      .mem_i_valid_o      (mem_i_valid_o),
      .mem_i_inst_o       (mem_i_inst_o),
      .mem_i_error_o      (mem_i_error_o),
      .mem_d_addr_i       (mem_d_addr_i),
      .mem_d_data_wr_i    (mem_d_data_wr_i),
      .mem_d_rd_i         (mem_d_rd_i),
      .mem_d_wr_i         (mem_d_wr_i),
      .mem_d_req_tag_i    (mem_d_req_tag_i),
      .mem_d_invalidate_i (mem_d_invalidate_i),
      .mem_d_writeback_i  (mem_d_writeback_i),
      .mem_d_flush_i      (mem_d_flush_i),
      .mem_d_accept_o     (mem_d_accept_o),
      .mem_d_ack_o        (mem_d_ack_o),
      .mem_d_data_rd_o    (mem_d_data_rd_o),
      .mem_d_error_o      (mem_d_error_o),
      .mem_d_resp_tag_o   (mem_d_resp_tag_o),
      .wb_cyc_o           (wb_cyc_o),
      .wb_stb_o           (wb_stb_o),
      .wb_we_o            (wb_we_o),
      .wb_sel_o           (wb_sel_o),
      .wb_adr_o           (wb_adr_o),
      .wb_dat_o           (wb_dat_o),
      .wb_dat_i           (wb_dat_i),
      .wb_ack_i           (wb_ack_i)
   );

   always #5 clk_i = ~clk_i;

   // Scoreboard: every response pulse must match the oldest queued request.
   always @(negedge clk_i) begin
      exp_t e;
      if (rst_i === 1'b0 && (mem_i_valid_o === 1'b1 || mem_d_ack_o === 1'b1)) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL resp_unexpected: got i_valid=%b d_ack=%b, required no response",
                     mem_i_valid_o, mem_d_ack_o);
         end else begin
            e = sb.pop_front();
            if (e.is_d) begin
               if (mem_d_ack_o !== 1'b1 || mem_i_valid_o !== 1'b0 ||
                   mem_d_data_rd_o !== e.data || mem_d_resp_tag_o !== e.tag ||
                   mem_d_error_o !== e.err)
                  $display("FAIL resp_d: got ack=%b ivalid=%b data=%h tag=%0d err=%b, required data=%h tag=%0d err=%b",
                           mem_d_ack_o, mem_i_valid_o, mem_d_data_rd_o, mem_d_resp_tag_o,
                           mem_d_error_o, e.data, e.tag, e.err);
               else
                  n_pass++;
            end else begin
               if (mem_i_valid_o !== 1'b1 || mem_d_ack_o !== 1'b0 ||
                   mem_i_inst_o !== e.data || mem_i_error_o !== e.err)
                  $display("FAIL resp_i: got valid=%b dack=%b inst=%h err=%b, required inst=%h err=%b",
                           mem_i_valid_o, mem_d_ack_o, mem_i_inst_o, mem_i_error_o,
                           e.data, e.err);
               else
                  n_pass++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      mem_i_rd_i         = 1'b0;
      mem_i_pc_i         = 32'h0;
      mem_i_flush_i      = 1'b0;
      mem_i_invalidate_i = 1'b0;
      mem_d_addr_i       = 32'h0;
      mem_d_data_wr_i    = 32'h0;
      mem_d_rd_i         = 1'b0;
      mem_d_wr_i         = 4'h0;
      mem_d_req_tag_i    = '0;
      mem_d_invalidate_i = 1'b0;
      mem_d_writeback_i  = 1'b0;
      mem_d_flush_i      = 1'b0;
   endtask

   task automatic test_reset();
      rst_i    = 1'b1;
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      clear_inputs();
      #1;
      n_checks++;
      if (all_out !== '0) $display("FAIL reset_outputs: got %h required 0", all_out);
      else n_pass++;
      tick();
      tick();
      rst_i = 1'b0;
      tick();
      n_checks++;
      if (all_out !== '0) $display("FAIL idle_outputs: got %h required 0", all_out);
      else n_pass++;
   endtask

   task automatic test_fetch();
      mem_i_pc_i = 32'h0000_0104;
      mem_i_rd_i = 1'b1;
      #1;
      n_checks++;
      if ({mem_i_accept_o, mem_d_accept_o} !== 2'b10)
         $display("FAIL fetch_accept: got i=%b d=%b required i=1 d=0", mem_i_accept_o, mem_d_accept_o);
      else n_pass++;
      sb.push_back('{1'b0, 32'h0000_0013, 11'd0, 1'b0});
      tick();
      mem_i_rd_i = 1'b0;
      n_checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o} !== {3'b110, 4'hF, 32'h104})
         $display("FAIL fetch_bus: got cyc=%b stb=%b we=%b sel=%h adr=%h required 1 1 0 f 104",
                  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o);
      else n_pass++;
      tick();
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h0000_0013;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      n_checks++;
      if ({wb_cyc_o, mem_i_valid_o, mem_i_error_o} !== 3'b010)
         $display("FAIL fetch_done: got cyc=%b valid=%b err=%b required 0 1 0",
                  wb_cyc_o, mem_i_valid_o, mem_i_error_o);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if (sb.size() != 0) $display("FAIL fetch_drain: got %0d pending required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_store();
      mem_d_wr_i      = 4'b0010;
      mem_d_data_wr_i = 32'hAABB_CCDD;
      mem_d_addr_i    = 32'h0000_2003;
      mem_d_req_tag_i = 11'd5;
      #1;
      n_checks++;
      if ({mem_i_accept_o, mem_d_accept_o} !== 2'b01)
         $display("FAIL store_accept: got i=%b d=%b required i=0 d=1", mem_i_accept_o, mem_d_accept_o);
      else n_pass++;
      sb.push_back('{1'b1, 32'h0, 11'd5, 1'b0});
      tick();
      clear_inputs();
      n_checks++;
      if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== {2'b11, 4'b0010, 32'h2000, 32'hAABB_CCDD})
         $display("FAIL store_bus: got cyc=%b we=%b sel=%b adr=%h dat=%h required 1 1 0010 2000 aabbccdd",
                  wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o);
      else n_pass++;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h1234_5678;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      n_checks++;
      if (wb_cyc_o !== 1'b0) $display("FAIL store_cyc_drop: got %b required 0", wb_cyc_o);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if (sb.size() != 0) $display("FAIL store_drain: got %0d pending required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_timeout();
      mem_d_rd_i      = 1'b1;
      mem_d_addr_i    = 32'h0000_0300;
      mem_d_req_tag_i = 11'd7;
      wb_dat_i        = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if (mem_d_accept_o !== 1'b1) $display("FAIL tmo_accept: got %b required 1", mem_d_accept_o);
      else n_pass++;
      sb.push_back('{1'b1, 32'h0, 11'd7, 1'b1});
      tick();
      clear_inputs();
      for (int c = 1; c <= int'(TMO); c++) begin
         n_checks++;
         if ({wb_cyc_o, mem_d_ack_o} !== 2'b10)
            $display("FAIL tmo_wait: cycle %0d got cyc=%b ack=%b required 1 0", c, wb_cyc_o, mem_d_ack_o);
         else n_pass++;
         tick();
      end
      n_checks++;
      if ({wb_cyc_o, mem_d_ack_o, mem_d_error_o} !== 3'b011 || mem_d_data_rd_o !== 32'h0)
         $display("FAIL tmo_abort: got cyc=%b ack=%b err=%b data=%h required 0 1 1 0",
                  wb_cyc_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o);
      else n_pass++;
      wb_dat_i = 32'h0;
      tick();
      tick();
      n_checks++;
      if (sb.size() != 0) $display("FAIL tmo_drain: got %0d pending required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_maintenance();
      mem_d_flush_i   = 1'b1;
      mem_d_req_tag_i = 11'd9;
      #1;
      n_checks++;
      if (mem_d_accept_o !== 1'b1) $display("FAIL maint_accept: got %b required 1", mem_d_accept_o);
      else n_pass++;
      sb.push_back('{1'b1, 32'h0, 11'd9, 1'b0});
      tick();
      clear_inputs();
      n_checks++;
      if ({wb_cyc_o, mem_d_ack_o} !== 2'b01 || mem_d_resp_tag_o !== 11'd9)
         $display("FAIL maint_ack: got cyc=%b ack=%b tag=%0d required 0 1 9",
                  wb_cyc_o, mem_d_ack_o, mem_d_resp_tag_o);
      else n_pass++;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h5555_AAAA;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      tick();
      n_checks++;
      if ({wb_cyc_o, mem_d_ack_o, mem_i_valid_o} !== 3'b000)
         $display("FAIL stray_ack: got cyc=%b dack=%b ivalid=%b required 0 0 0",
                  wb_cyc_o, mem_d_ack_o, mem_i_valid_o);
      else n_pass++;
      mem_i_flush_i      = 1'b1;
      mem_i_invalidate_i = 1'b1;
      #1;
      n_checks++;
      if ({mem_i_accept_o, mem_d_accept_o} !== 2'b00)
         $display("FAIL imaint_accept: got i=%b d=%b required 0 0", mem_i_accept_o, mem_d_accept_o);
      else n_pass++;
      tick();
      clear_inputs();
      n_checks++;
      if (wb_cyc_o !== 1'b0) $display("FAIL imaint_bus: got cyc=%b required 0", wb_cyc_o);
      else n_pass++;
      tick();
      n_checks++;
      if (sb.size() != 0) $display("FAIL maint_drain: got %0d pending required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      mem_d_rd_i      = 1'b1;
      mem_d_addr_i    = 32'h0000_0400;
      mem_d_req_tag_i = 11'd1;
      tick();
      clear_inputs();
      n_checks++;
      if (wb_cyc_o !== 1'b1) $display("FAIL rstmid_cyc: got %b required 1", wb_cyc_o);
      else n_pass++;
      #2;
      rst_i = 1'b1;
      #1;
      n_checks++;
      if (all_out !== '0) $display("FAIL rstmid_outputs: got %h required 0", all_out);
      else n_pass++;
      tick();
      tick();
      rst_i    = 1'b0;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h7777_7777;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      tick();
      tick();
      mem_d_rd_i      = 1'b1;
      mem_d_addr_i    = 32'h0000_0500;
      mem_d_req_tag_i = 11'd2;
      #1;
      n_checks++;
      if (mem_d_accept_o !== 1'b1) $display("FAIL rstmid_accept: got %b required 1", mem_d_accept_o);
      else n_pass++;
      sb.push_back('{1'b1, 32'hCAFE_0001, 11'd2, 1'b0});
      tick();
      clear_inputs();
      n_checks++;
      if ({wb_cyc_o, wb_we_o, wb_adr_o} !== {2'b10, 32'h500})
         $display("FAIL rstmid_bus: got cyc=%b we=%b adr=%h required 1 0 500", wb_cyc_o, wb_we_o, wb_adr_o);
      else n_pass++;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hCAFE_0001;
      tick();
      wb_ack_i = 1'b0;
      wb_dat_i = 32'h0;
      tick();
      tick();
      n_checks++;
      if (sb.size() != 0) $display("FAIL rstmid_drain: got %0d pending required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic exp_d;
      logic [31:0] d;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tick();
      mem_i_rd_i      = 1'b1;
      mem_i_pc_i      = 32'h0000_0040;
      mem_d_rd_i      = 1'b1;
      mem_d_addr_i    = 32'h0000_0080;
      mem_d_req_tag_i = 11'd3;
      exp_d = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if ({mem_d_accept_o, mem_i_accept_o} !== {exp_d, ~exp_d})
            $display("FAIL rr_grant%0d: got d=%b i=%b required d=%b i=%b",
                     k, mem_d_accept_o, mem_i_accept_o, exp_d, ~exp_d);
         else n_pass++;
         d = exp_d ? (32'hD000_0000 + 32'(k)) : (32'h1000_0000 + 32'(k));
         sb.push_back('{exp_d, d, 11'd3, 1'b0});
         tick();
         n_checks++;
         if ({mem_d_accept_o, mem_i_accept_o} !== 2'b00 ||
             wb_adr_o !== (exp_d ? 32'h80 : 32'h40))
            $display("FAIL rr_bus%0d: got dacc=%b iacc=%b adr=%h required 0 0 %h",
                     k, mem_d_accept_o, mem_i_accept_o, wb_adr_o, exp_d ? 32'h80 : 32'h40);
         else n_pass++;
         wb_ack_i = 1'b1;
         wb_dat_i = d;
         tick();
         wb_ack_i = 1'b0;
         wb_dat_i = 32'h0;
         exp_d = ~exp_d;
      end
      clear_inputs();
      tick();
      tick();
      n_checks++;
      if (sb.size() != 0) $display("FAIL rr_drain: got %0d pending required 0", sb.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_timeout();
      test_maintenance();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_time_limit: got no completion, required finish before 100000");
      $fatal(1);
   end

endmodule
